// File: rtl/llc_snoop_responder_pkg.sv
// LLC_defs: shared bus-operation and snoop-result encodings used on the LLC
// bus, plus the types for the remote-cache directory kept by the snoop responder.
package LLC_defs;

    typedef enum logic [2:0] {
        NOBUSOP    = 3'd0,
        READ       = 3'd1,
        WRITE      = 3'd2,
        INVALIDATE = 3'd3,
        RWIM       = 3'd4
    } busOperation;

    typedef enum logic [1:0] {
        NOHIT    = 2'd0,
        HIT      = 2'd1,
        HITM     = 2'd2,
        NORESULT = 2'd3
    } snoopResults;

    typedef enum logic [1:0] {
        SD_INV = 2'd0,
        SD_SHR = 2'd1,
        SD_MOD = 2'd2
    } snoop_dir_state_t;

    localparam int ADDR_W = 32;

    // The tag is stored full-width (address shifted right by the line offset)
    // so the entry layout does not depend on the line-offset parameter.
    typedef struct packed {
        logic             valid;
        logic [ADDR_W-1:0] tag;
        snoop_dir_state_t state;
    } snoop_dir_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOOKUP  = 2'd1,
        ST_RESPOND = 2'd2
    } snoop_fsm_t;

endpackage

// File: rtl/llc_snoop_responder_if.sv
// Bus between the LLC (master) and the snoop responder (slave): request,
// snoop response and the bench-driven remote-line install channel.
interface llc_snoop_responder_if;
    import LLC_defs::*;

    logic        req_valid;
    logic        req_ready;
    busOperation req_busop;
    logic [31:0] req_addr;

    logic        resp_valid;
    snoopResults resp_result;
    logic [31:0] resp_addr;

    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_addr;
    logic        inst_modified;

    modport master (
        output req_valid, req_busop, req_addr,
        output inst_valid, inst_addr, inst_modified,
        input  req_ready, resp_valid, resp_result, resp_addr, inst_ready
    );

    modport slave (
        input  req_valid, req_busop, req_addr,
        input  inst_valid, inst_addr, inst_modified,
        output req_ready, resp_valid, resp_result, resp_addr, inst_ready
    );

endinterface

// File: rtl/llc_snoop_responder_snoop_dir.sv
// snoop_dir: small fully-associative directory of lines held by remote caches.
// Provides a lookup port, an update port (state change / invalidate of the
// looked-up entry) and an install port with lowest-free / round-robin placement.
module snoop_dir
    import LLC_defs::*;
#(
    parameter int DIR_ENTRIES = 8,
    parameter int IDX_W       = $clog2(DIR_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      lk_tag,
    output logic             lk_hit,
    output logic [IDX_W-1:0] lk_idx,
    output snoop_dir_state_t lk_state,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  snoop_dir_state_t upd_state,
    input  logic             ins_en,
    input  logic [31:0]      ins_tag,
    input  snoop_dir_state_t ins_state,
    output logic             dir_full
);

    snoop_dir_entry_t entry_q [DIR_ENTRIES];
    snoop_dir_entry_t entry_d [DIR_ENTRIES];
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    logic             ins_hit;
    logic [IDX_W-1:0] ins_hit_idx;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;

    // Request lookup: installs keep tags unique, so the first match is the only one.
    always_comb begin
        lk_hit   = 1'b0;
        lk_idx   = '0;
        lk_state = SD_INV;
        for (int i = 0; i < DIR_ENTRIES; i++) begin
            if (!lk_hit && entry_q[i].valid && entry_q[i].tag == lk_tag) begin
                lk_hit   = 1'b1;
                lk_idx   = IDX_W'(i);
                lk_state = entry_q[i].state;
            end
        end
    end

    // Install placement: existing match, else lowest free slot, plus the full flag.
    always_comb begin
        ins_hit     = 1'b0;
        ins_hit_idx = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        dir_full    = 1'b1;
        for (int i = 0; i < DIR_ENTRIES; i++) begin
            if (!ins_hit && entry_q[i].valid && entry_q[i].tag == ins_tag) begin
                ins_hit     = 1'b1;
                ins_hit_idx = IDX_W'(i);
            end
            if (!free_found && !entry_q[i].valid) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (!entry_q[i].valid) begin
                dir_full = 1'b0;
            end
        end
    end

    // Next directory contents: a request update wins over an install (they never coincide).
    always_comb begin
        entry_d  = entry_q;
        rr_ptr_d = rr_ptr_q;
        if (upd_en) begin
            if (upd_state == SD_INV) begin
                entry_d[upd_idx].valid = 1'b0;
                entry_d[upd_idx].state = SD_INV;
            end else begin
                entry_d[upd_idx].state = upd_state;
            end
        end else if (ins_en) begin
            if (ins_hit) begin
                entry_d[ins_hit_idx].state = ins_state;
            end else if (free_found) begin
                entry_d[free_idx].valid = 1'b1;
                entry_d[free_idx].tag   = ins_tag;
                entry_d[free_idx].state = ins_state;
            end else begin
                entry_d[rr_ptr_q].valid = 1'b1;
                entry_d[rr_ptr_q].tag   = ins_tag;
                entry_d[rr_ptr_q].state = ins_state;
                rr_ptr_d = rr_ptr_q + IDX_W'(1);
            end
        end
    end

    // Directory and victim-pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIR_ENTRIES; i++) begin
                entry_q[i] <= '0;
            end
            rr_ptr_q <= '0;
        end else begin
            entry_q  <= entry_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/llc_snoop_responder.sv
// llc_snoop_responder: models the other processors' caches on the LLC bus.
// Accepts one bus operation at a time, looks it up in the remote directory and
// returns a one-cycle snoop response two edges after acceptance.
// Optional build macro: SNOOP_LSB_MODEL_EN -- snoop result taken from the low
// two address bits instead of the directory; requests never touch the directory.
module llc_snoop_responder
    import LLC_defs::*;
#(
    parameter int DIR_ENTRIES = 8,
    parameter int LINE_OFF    = 6,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    llc_snoop_responder_if.slave bus,
    output logic                 dir_full,
    output logic                 err,
    output logic [CNT_W-1:0]     req_cnt
);

    localparam int IDX_W = $clog2(DIR_ENTRIES);

    snoop_fsm_t  state_q, state_d;
    busOperation busop_q, busop_d;
    logic [31:0] addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        resp_valid_q, resp_valid_d;
    snoopResults resp_result_q, resp_result_d;
    logic [31:0] resp_addr_q, resp_addr_d;

    logic             lk_hit;
    logic [IDX_W-1:0] lk_idx;
    snoop_dir_state_t lk_state;
    snoopResults      snoop_res;
    logic             upd_req;
    snoop_dir_state_t upd_state;
    logic             err_set;
    logic             ins_en;

    assign bus.req_ready   = (state_q == ST_IDLE);
    assign bus.inst_ready  = (state_q == ST_IDLE) && !bus.req_valid;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_result = resp_result_q;
    assign bus.resp_addr   = resp_addr_q;
    assign err             = err_q;
    assign req_cnt         = cnt_q;
    assign ins_en          = bus.inst_valid && bus.inst_ready;

    snoop_dir #(
        .DIR_ENTRIES (DIR_ENTRIES),
        .IDX_W       (IDX_W)
    ) u_dir (
        .clk       (clk),
        .rst_n     (rst_n),
        .lk_tag    (addr_q >> LINE_OFF),
        .lk_hit    (lk_hit),
        .lk_idx    (lk_idx),
        .lk_state  (lk_state),
        .upd_en    (upd_req && (state_q == ST_LOOKUP)),
        .upd_idx   (lk_idx),
        .upd_state (upd_state),
        .ins_en    (ins_en),
        .ins_tag   (bus.inst_addr >> LINE_OFF),
        .ins_state (bus.inst_modified ? SD_MOD : SD_SHR),
        .dir_full  (dir_full)
    );

    // Snoop result and directory side effect for the latched operation.
    always_comb begin
        snoop_res = NORESULT;
        upd_req   = 1'b0;
        upd_state = SD_INV;
        err_set   = 1'b0;
`ifdef SNOOP_LSB_MODEL_EN
        if (busop_q != NOBUSOP) begin
            case (addr_q[1:0])
                2'b00:   snoop_res = HIT;
                2'b01:   snoop_res = HITM;
                default: snoop_res = NOHIT;
            endcase
        end
`else
        case (busop_q)
            READ: begin
                snoop_res = NOHIT;
                if (lk_hit) begin
                    if (lk_state == SD_MOD) begin
                        snoop_res = HITM;
                        upd_req   = 1'b1;
                        upd_state = SD_SHR;
                    end else begin
                        snoop_res = HIT;
                    end
                end
            end
            WRITE: begin
                snoop_res = NOHIT;
                if (lk_hit) begin
                    upd_req = 1'b1;
                    err_set = 1'b1;
                end
            end
            INVALIDATE, RWIM: begin
                snoop_res = NOHIT;
                if (lk_hit) begin
                    snoop_res = (lk_state == SD_MOD) ? HITM : HIT;
                    upd_req   = 1'b1;
                    err_set   = (busop_q == INVALIDATE) && (lk_state == SD_MOD);
                end
            end
            default: snoop_res = NORESULT;
        endcase
`endif
    end

    // Request FSM: accept in IDLE, resolve in LOOKUP, present the response in RESPOND.
    always_comb begin
        state_d       = state_q;
        busop_d       = busop_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        resp_valid_d  = 1'b0;
        resp_result_d = resp_result_q;
        resp_addr_d   = resp_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    state_d = ST_LOOKUP;
                    busop_d = bus.req_busop;
                    addr_d  = bus.req_addr;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_LOOKUP: begin
                state_d       = ST_RESPOND;
                resp_valid_d  = 1'b1;
                resp_result_d = snoop_res;
                resp_addr_d   = addr_q;
                if (err_set) begin
                    err_d = 1'b1;
                end
            end
            ST_RESPOND: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Control and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            busop_q       <= NOBUSOP;
            addr_q        <= '0;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_result_q <= NORESULT;
            resp_addr_q   <= '0;
        end else begin
            state_q       <= state_d;
            busop_q       <= busop_d;
            addr_q        <= addr_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
            resp_valid_q  <= resp_valid_d;
            resp_result_q <= resp_result_d;
            resp_addr_q   <= resp_addr_d;
        end
    end

endmodule

// File: tb/tb_llc_snoop_responder.sv
// Testbench for llc_snoop_responder: directed scenarios followed by random
// installs/requests, all checked against a line-level model of the remote caches.
module tb_llc_snoop_responder;
    import LLC_defs::*;

    localparam int DIR_ENTRIES = 8;
    localparam int LINE_OFF    = 6;
    localparam int CNT_W       = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic dir_full;
    logic err;
    logic [CNT_W-1:0] req_cnt;

    int total = 0;
    int bad   = 0;

    llc_snoop_responder_if bus();

    llc_snoop_responder #(
        .DIR_ENTRIES (DIR_ENTRIES),
        .LINE_OFF    (LINE_OFF),
        .CNT_W       (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .dir_full (dir_full),
        .err      (err),
        .req_cnt  (req_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: remote lines as (line number, modified flag) slots.
    bit          m_valid [DIR_ENTRIES];
    logic [31:0] m_line  [DIR_ENTRIES];
    bit          m_mod   [DIR_ENTRIES];
    int          m_rr;
    bit          m_err;
    int          m_cnt;

    function automatic void modelReset();
        for (int i = 0; i < DIR_ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_line[i]  = '0;
            m_mod[i]   = 1'b0;
        end
        m_rr  = 0;
        m_err = 1'b0;
        m_cnt = 0;
    endfunction

    function automatic bit modelFull();
        for (int i = 0; i < DIR_ENTRIES; i++) begin
            if (!m_valid[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void modelInstall(logic [31:0] addr, bit modified);
        logic [31:0] line = addr / (32'd1 << LINE_OFF);
        for (int i = 0; i < DIR_ENTRIES; i++) begin
            if (m_valid[i] && m_line[i] == line) begin
                m_mod[i] = modified;
                return;
            end
        end
        for (int i = 0; i < DIR_ENTRIES; i++) begin
            if (!m_valid[i]) begin
                m_valid[i] = 1'b1;
                m_line[i]  = line;
                m_mod[i]   = modified;
                return;
            end
        end
        m_line[m_rr] = line;
        m_mod[m_rr]  = modified;
        m_rr = (m_rr + 1) % DIR_ENTRIES;
    endfunction

    function automatic snoopResults modelRequest(busOperation op, logic [31:0] addr);
        int hit = -1;
        logic [31:0] line = addr / (32'd1 << LINE_OFF);
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
`ifdef SNOOP_LSB_MODEL_EN
        if (op == NOBUSOP) return NORESULT;
        if (addr[1:0] == 2'b00) return HIT;
        if (addr[1:0] == 2'b01) return HITM;
        return NOHIT;
`else
        for (int i = 0; i < DIR_ENTRIES; i++) begin
            if (m_valid[i] && m_line[i] == line) hit = i;
        end
        case (op)
            READ: begin
                if (hit < 0) return NOHIT;
                if (m_mod[hit]) begin
                    m_mod[hit] = 1'b0;
                    return HITM;
                end
                return HIT;
            end
            WRITE: begin
                if (hit >= 0) begin
                    m_valid[hit] = 1'b0;
                    m_err = 1'b1;
                end
                return NOHIT;
            end
            INVALIDATE, RWIM: begin
                snoopResults r;
                if (hit < 0) return NOHIT;
                r = m_mod[hit] ? HITM : HIT;
                if (m_mod[hit] && op == INVALIDATE) m_err = 1'b1;
                m_valid[hit] = 1'b0;
                return r;
            end
            default: return NORESULT;
        endcase
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // mode 0: request, 1: install, 2: request and install together (request wins)
    task automatic applyStimulus(input int mode, input busOperation op, input logic [31:0] addr,
                                 input bit modified, output snoopResults got);
        snoopResults exp_res;
        got = NORESULT;
        @(posedge clk);
        #1;
        if (mode == 1) begin
            bus.inst_valid    = 1'b1;
            bus.inst_addr     = addr;
            bus.inst_modified = modified;
            @(negedge clk);
            checkOutput("inst_ready", 32'(bus.inst_ready), 32'd1);
            modelInstall(addr, modified);
            @(posedge clk);
            #1;
            bus.inst_valid = 1'b0;
            @(negedge clk);
            checkOutput("dir_full", 32'(dir_full), 32'(modelFull()));
        end else begin
            bus.req_valid = 1'b1;
            bus.req_busop = op;
            bus.req_addr  = addr;
            if (mode == 2) begin
                bus.inst_valid    = 1'b1;
                bus.inst_addr     = addr ^ 32'h0000_0400;
                bus.inst_modified = modified;
            end
            @(negedge clk);
            checkOutput("req_ready_idle", 32'(bus.req_ready), 32'd1);
            checkOutput("inst_blocked", 32'(bus.inst_ready), 32'd0);
            exp_res = modelRequest(op, addr);
            @(posedge clk);
            #1;
            bus.req_valid  = 1'b0;
            bus.inst_valid = 1'b0;
            bus.req_busop  = NOBUSOP;
            bus.req_addr   = $urandom;
            @(negedge clk);
            checkOutput("lookup_no_resp", 32'(bus.resp_valid), 32'd0);
            checkOutput("lookup_busy", 32'(bus.req_ready), 32'd0);
            @(negedge clk);
            checkOutput("resp_valid", 32'(bus.resp_valid), 32'd1);
            checkOutput("resp_result", 32'(bus.resp_result), 32'(exp_res));
            checkOutput("resp_addr", bus.resp_addr, addr);
            checkOutput("err", 32'(err), 32'(m_err));
            checkOutput("req_cnt", 32'(req_cnt), 32'(m_cnt));
            checkOutput("dir_full_req", 32'(dir_full), 32'(modelFull()));
            got = bus.resp_result;
            @(negedge clk);
            checkOutput("resp_pulse_end", 32'(bus.resp_valid), 32'd0);
            checkOutput("req_ready_back", 32'(bus.req_ready), 32'd1);
        end
    endtask

    initial begin
        snoopResults got;
        int          kind;
        logic [31:0] addr;
        busOperation op;

        bus.req_valid     = 1'b0;
        bus.req_busop     = NOBUSOP;
        bus.req_addr      = '0;
        bus.inst_valid    = 1'b0;
        bus.inst_addr     = '0;
        bus.inst_modified = 1'b0;
        modelReset();

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        checkOutput("rst_resp_result", 32'(bus.resp_result), 32'(NORESULT));
        checkOutput("rst_resp_addr", bus.resp_addr, 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_req_cnt", 32'(req_cnt), 32'd0);
        checkOutput("rst_dir_full", 32'(dir_full), 32'd0);
        checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd1);

`ifdef SNOOP_LSB_MODEL_EN
        applyStimulus(0, READ, 32'h0000_0100, 1'b0, got);
        checkOutput("lsb_hit", 32'(got), 32'(HIT));
        applyStimulus(0, READ, 32'h0000_0101, 1'b0, got);
        checkOutput("lsb_hitm", 32'(got), 32'(HITM));
        applyStimulus(0, READ, 32'h0000_0102, 1'b0, got);
        checkOutput("lsb_nohit", 32'(got), 32'(NOHIT));
        applyStimulus(0, NOBUSOP, 32'h0000_0100, 1'b0, got);
        checkOutput("lsb_nobusop", 32'(got), 32'(NORESULT));
`else
        applyStimulus(1, NOBUSOP, 32'h0000_1040, 1'b1, got);
        applyStimulus(0, READ, 32'h0000_1044, 1'b0, got);
        checkOutput("read_mod_hitm", 32'(got), 32'(HITM));
        applyStimulus(0, READ, 32'h0000_1044, 1'b0, got);
        checkOutput("read_shr_hit", 32'(got), 32'(HIT));

        applyStimulus(1, NOBUSOP, 32'h0000_2000, 1'b0, got);
        applyStimulus(0, RWIM, 32'h0000_2000, 1'b0, got);
        checkOutput("rwim_shr_hit", 32'(got), 32'(HIT));
        applyStimulus(0, READ, 32'h0000_2000, 1'b0, got);
        checkOutput("read_after_rwim", 32'(got), 32'(NOHIT));

        applyStimulus(1, NOBUSOP, 32'h0000_3000, 1'b1, got);
        applyStimulus(0, INVALIDATE, 32'h0000_3000, 1'b0, got);
        checkOutput("inval_mod_hitm", 32'(got), 32'(HITM));
        checkOutput("inval_mod_err", 32'(err), 32'd1);
        applyStimulus(0, READ, 32'h0000_5000, 1'b0, got);
        checkOutput("err_sticky", 32'(err), 32'd1);
`endif

        // Reset while the request sits in LOOKUP: no response may follow.
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_busop = READ;
        bus.req_addr  = 32'h0000_1040;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        modelReset();
        @(negedge clk);
        checkOutput("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
        checkOutput("midrst_req_cnt", 32'(req_cnt), 32'd0);
        checkOutput("midrst_err", 32'(err), 32'd0);
        checkOutput("midrst_req_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        checkOutput("midrst_no_late_resp", 32'(bus.resp_valid), 32'd0);

        // Fill the directory and push one more line to force round-robin eviction.
        for (int i = 0; i < DIR_ENTRIES + 1; i++) begin
            applyStimulus(1, NOBUSOP, 32'h0001_0000 + 32'(i * 64), 1'b0, got);
            if (i == DIR_ENTRIES - 2) checkOutput("not_full_yet", 32'(dir_full), 32'd0);
        end
        checkOutput("full_after_fill", 32'(dir_full), 32'd1);
`ifndef SNOOP_LSB_MODEL_EN
        applyStimulus(0, READ, 32'h0001_0000, 1'b0, got);
        checkOutput("evicted_first", 32'(got), 32'(NOHIT));
        applyStimulus(0, READ, 32'h0001_0040, 1'b0, got);
        checkOutput("kept_second", 32'(got), 32'(HIT));
`endif

        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 9);
            addr = 32'h0004_0000 + ($urandom_range(0, 11) << LINE_OFF) + $urandom_range(0, 63);
            op   = busOperation'(3'($urandom_range(0, 7)));
            if (kind < 4) begin
                applyStimulus(1, op, addr, 1'($urandom_range(0, 1)), got);
            end else if (kind == 4) begin
                applyStimulus(2, op, addr, 1'($urandom_range(0, 1)), got);
            end else begin
                applyStimulus(0, op, addr, 1'b0, got);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
